// File: rtl/memory_ram_pkg.sv
// Shared types and defaults for the memory_ram_bus slave: FSM state encoding,
// default parameter values and the wait-state counter sizing.
package memory_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 8;
  localparam int DEPTH_DEF       = 256;
  localparam int WAIT_STATES_DEF = 1;
  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

  // Counter preload on acceptance; only meaningful when wait states exist.
  function automatic logic [CNT_W-1:0] wait_load(input int ws);
    return (ws > 0) ? CNT_W'(ws - 1) : '0;
  endfunction

endpackage

// File: rtl/memory_ram_array.sv
// Word storage for memory_ram_bus: synchronous byte-masked write and
// synchronous read into a holding register. Contents are never reset.
module memory_ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_ram_bus.sv
// Single-port RAM slave with ready/valid handshake and WAIT_STATES latency.
// Define MEMORY_RAM_BYTE_STROBE_EN to honour iRAM_BE on writes; otherwise writes are full-word.
module memory_ram_bus
  import memory_ram_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic                iRAM_CLK,
  input  logic                iRAM_RST,
  input  logic                iRAM_REQ,
  input  logic                iRAM_WE,
  input  logic [ADDR_W-1:0]   iRAM_ADDR,
  input  logic [DATA_W-1:0]   iRAM_DATA,
  input  logic [DATA_W/8-1:0] iRAM_BE,
  output logic                oRAM_READY,
  output logic                oRAM_VALID,
  output logic [DATA_W-1:0]   oRAM_DATA,
  output logic                oRAM_ERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                rsel_q, rsel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] be_q, be_d;

  logic                accept;
  logic                acc_en;
  logic                acc_we;
  logic                in_range;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;
  logic [DATA_W/8-1:0] acc_be;
  logic [DATA_W/8-1:0] be_eff;
  logic                arr_wr_en, arr_rd_en;
  logic [DATA_W-1:0]   arr_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    rsel_d   = rsel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    data_d   = data_q;
    be_d     = be_q;
    acc_en   = 1'b0;
    acc_we   = we_q;
    acc_addr = addr_q;
    acc_data = data_q;
    acc_be   = be_q;
    accept   = iRAM_REQ && ready_q;

    case (state_q)
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (accept) begin
          addr_d = iRAM_ADDR;
          we_d   = iRAM_WE;
          data_d = iRAM_DATA;
          be_d   = iRAM_BE;
          // Zero wait states: the access happens on the accepting edge itself,
          // so the array must see the live request rather than the latch.
          if (WAIT_STATES == 0) begin
            state_d  = RESP;
            acc_en   = 1'b1;
            acc_we   = iRAM_WE;
            acc_addr = iRAM_ADDR;
            acc_data = iRAM_DATA;
            acc_be   = iRAM_BE;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_load(WAIT_STATES);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    in_range = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
    if (acc_en) begin
      valid_d = 1'b1;
      err_d   = !in_range;
      rsel_d  = !acc_we && in_range;
    end
    ready_d = (state_d != WAIT);
  end

`ifdef MEMORY_RAM_BYTE_STROBE_EN
  assign be_eff = acc_be;
`else
  assign be_eff = '1;
`endif

  // Gating with reset keeps an aborted transaction from touching the array.
  assign arr_wr_en = acc_en && acc_we && in_range && iRAM_RST;
  assign arr_rd_en = acc_en && !acc_we && in_range && iRAM_RST;

  always_ff @(posedge iRAM_CLK) begin
    addr_q <= addr_d;
    we_q   <= we_d;
    data_q <= data_d;
    be_q   <= be_d;
    if (!iRAM_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rsel_q  <= rsel_d;
    end
  end

  memory_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (iRAM_CLK),
    .wr_en (arr_wr_en),
    .rd_en (arr_rd_en),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (acc_data),
    .be    (be_eff),
    .rdata (arr_rdata)
  );

  // Read data register holds between responses; writes and errors present zero.
  assign oRAM_DATA  = rsel_q ? arr_rdata : '0;
  assign oRAM_READY = ready_q;
  assign oRAM_VALID = valid_q;
  assign oRAM_ERR   = err_q;

endmodule

// File: tb/tb_memory_ram_bus.sv
// Directed bench for memory_ram_bus: three instances cover one, zero and three
// wait states plus a partially populated address space.
module tb_memory_ram_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Instance A: WAIT_STATES=1, DEPTH=200
  logic        a_rst, a_req, a_we, a_ready, a_valid, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_be;
  // Instance B: WAIT_STATES=0
  logic        b_rst, b_req, b_we, b_ready, b_valid, b_err;
  logic [7:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic [3:0]  b_be;
  // Instance C: WAIT_STATES=3
  logic        c_rst, c_req, c_we, c_ready, c_valid, c_err;
  logic [7:0]  c_addr;
  logic [31:0] c_din, c_dout;
  logic [3:0]  c_be;

  memory_ram_bus #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(1)) u_a (
    .iRAM_CLK(clk), .iRAM_RST(a_rst), .iRAM_REQ(a_req), .iRAM_WE(a_we),
    .iRAM_ADDR(a_addr), .iRAM_DATA(a_din), .iRAM_BE(a_be),
    .oRAM_READY(a_ready), .oRAM_VALID(a_valid), .oRAM_DATA(a_dout), .oRAM_ERR(a_err));

  memory_ram_bus #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_b (
    .iRAM_CLK(clk), .iRAM_RST(b_rst), .iRAM_REQ(b_req), .iRAM_WE(b_we),
    .iRAM_ADDR(b_addr), .iRAM_DATA(b_din), .iRAM_BE(b_be),
    .oRAM_READY(b_ready), .oRAM_VALID(b_valid), .oRAM_DATA(b_dout), .oRAM_ERR(b_err));

  memory_ram_bus #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_c (
    .iRAM_CLK(clk), .iRAM_RST(c_rst), .iRAM_REQ(c_req), .iRAM_WE(c_we),
    .iRAM_ADDR(c_addr), .iRAM_DATA(c_din), .iRAM_BE(c_be),
    .oRAM_READY(c_ready), .oRAM_VALID(c_valid), .oRAM_DATA(c_dout), .oRAM_ERR(c_err));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic a_xact(input logic we, input logic [7:0] addr, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    a_req = 1'b1; a_we = we; a_addr = addr; a_din = d; a_be = be;
    tick;
    a_req = 1'b0;
    lat = 1;
    while (a_valid !== 1'b1 && lat < 12) begin
      tick;
      lat++;
    end
    rd = a_dout;
    er = a_err;
  endtask

  task automatic c_xact(input logic we, input logic [7:0] addr, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    c_req = 1'b1; c_we = we; c_addr = addr; c_din = d; c_be = be;
    tick;
    c_req = 1'b0;
    lat = 1;
    while (c_valid !== 1'b1 && lat < 12) begin
      tick;
      lat++;
    end
    rd = c_dout;
    er = c_err;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] pat [4];
    logic [31:0] exp_be;

    pat = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_FFFF, 32'h8000_0001};
`ifdef MEMORY_RAM_BYTE_STROBE_EN
    exp_be = 32'h11BB_33DD;
`else
    exp_be = 32'hAABB_CCDD;
`endif

    a_rst = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0; a_be = '0;
    b_rst = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0; b_be = 4'hF;
    c_rst = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_din = '0; c_be = '0;
    tick;
    tick;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data",  a_dout,       32'd0);
    chk("rst_a_err",   32'(a_err),   32'd0);
    chk("rst_c_ready", 32'(c_ready), 32'd1);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick;

    // ---- A: write then read with one wait state ----
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_din = 32'hDEAD_BEEF; a_be = 4'hF;
    tick;
    a_req = 1'b0;
    chk("a_wr_wait_ready", 32'(a_ready), 32'd0);
    chk("a_wr_wait_valid", 32'(a_valid), 32'd0);
    tick;
    chk("a_wr_resp_valid", 32'(a_valid), 32'd1);
    chk("a_wr_resp_err",   32'(a_err),   32'd0);
    chk("a_wr_resp_data",  a_dout,       32'd0);
    chk("a_wr_resp_ready", 32'(a_ready), 32'd1);
    tick;
    chk("a_idle_valid", 32'(a_valid), 32'd0);
    a_xact(1'b0, 8'h10, 32'h0, 4'hF, rd, er, lat);
    chk("a_rd_latency", 32'(lat), 32'd2);
    chk("a_rd_data",    rd,       32'hDEAD_BEEF);
    chk("a_rd_err",     32'(er),  32'd0);
    tick;
    chk("a_hold_valid", 32'(a_valid), 32'd0);
    chk("a_hold_data",  a_dout,       32'hDEAD_BEEF);

    // ---- A: byte strobes, back-to-back from RESP ----
    a_xact(1'b1, 8'h20, 32'h1122_3344, 4'hF, rd, er, lat);
    a_xact(1'b1, 8'h20, 32'hAABB_CCDD, 4'h5, rd, er, lat);
    chk("a_be_wr_latency", 32'(lat), 32'd2);
    a_xact(1'b0, 8'h20, 32'h0, 4'hF, rd, er, lat);
    chk("a_be_readback", rd, exp_be);

    // ---- A: address range boundary (DEPTH=200) ----
    a_xact(1'b1, 8'h00, 32'h1234_5678, 4'hF, rd, er, lat);
    a_xact(1'b1, 8'hC7, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chk("a_last_wr_err", 32'(er), 32'd0);
    a_xact(1'b0, 8'hC8, 32'h0, 4'hF, rd, er, lat);
    chk("a_oor_rd_err",  32'(er), 32'd1);
    chk("a_oor_rd_data", rd,      32'd0);
    a_xact(1'b1, 8'hC8, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("a_oor_wr_err", 32'(er), 32'd1);
    a_xact(1'b0, 8'h00, 32'h0, 4'hF, rd, er, lat);
    chk("a_addr0_data", rd,      32'h1234_5678);
    chk("a_addr0_err",  32'(er), 32'd0);
    a_xact(1'b0, 8'hC7, 32'h0, 4'hF, rd, er, lat);
    chk("a_last_rd_data", rd, 32'hCAFE_F00D);
    tick;

    // ---- B: zero wait states, request held, alternating write/read ----
    b_req = 1'b1; b_addr = 8'h03;
    for (int i = 0; i < 4; i++) begin
      b_we = 1'b1; b_din = pat[i];
      tick;
      chk("b_wr_valid", 32'(b_valid), 32'd1);
      chk("b_wr_ready", 32'(b_ready), 32'd1);
      chk("b_wr_data",  b_dout,       32'd0);
      b_we = 1'b0;
      tick;
      chk("b_rd_valid", 32'(b_valid), 32'd1);
      chk("b_rd_ready", 32'(b_ready), 32'd1);
      chk("b_rd_data",  b_dout,       pat[i]);
    end
    b_req = 1'b0;
    tick;
    chk("b_idle_valid", 32'(b_valid), 32'd0);
    chk("b_idle_ready", 32'(b_ready), 32'd1);
    chk("b_idle_err",   32'(b_err),   32'd0);
    chk("b_hold_data",  b_dout,       pat[3]);

    // ---- C: reset in the middle of a three-wait-state write ----
    c_xact(1'b1, 8'h05, 32'h0BAD_F00D, 4'hF, rd, er, lat);
    chk("c_wr_latency", 32'(lat), 32'd4);
    tick;
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h05; c_din = 32'hCAFE_BABE; c_be = 4'hF;
    tick;
    c_req = 1'b0;
    chk("c_wait1_ready", 32'(c_ready), 32'd0);
    tick;
    chk("c_wait2_ready", 32'(c_ready), 32'd0);
    chk("c_wait2_valid", 32'(c_valid), 32'd0);
    c_rst = 1'b0;
    tick;
    c_rst = 1'b1;
    chk("c_abort_ready", 32'(c_ready), 32'd1);
    chk("c_abort_valid", 32'(c_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("c_no_resp_valid", 32'(c_valid), 32'd0);
    end
    c_xact(1'b0, 8'h05, 32'h0, 4'hF, rd, er, lat);
    chk("c_rd_latency", 32'(lat), 32'd4);
    chk("c_rd_old_data", rd, 32'h0BAD_F00D);
    chk("c_rd_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_ram_bus.md
MEMORY_RAM_BUS -- requirements
Module: memory_ram_bus

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning implemented words (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between acceptance and response (range 0..15).
REQ-005 The block SHALL have port iRAM_CLK  in  1  clock; one clock, all logic on rising edge.
REQ-006 The block SHALL have port iRAM_RST  in  1  reset; synchronous, active-low.
REQ-007 The block SHALL have port iRAM_REQ  in  1  request valid.
REQ-008 The block SHALL have port iRAM_WE  in  1  1 = write, 0 = read.
REQ-009 The block SHALL have port iRAM_ADDR  in  ADDR_W  word address.
REQ-010 The block SHALL have port iRAM_DATA  in  DATA_W  write data.
REQ-011 The block SHALL have port iRAM_BE  in  DATA_W/8  byte write strobes.
REQ-012 The block SHALL have port oRAM_READY  out  1  request can be accepted this cycle.
REQ-013 The block SHALL have port oRAM_VALID  out  1  one-cycle response strobe.
REQ-014 The block SHALL have port oRAM_DATA  out  DATA_W  registered read data.
REQ-015 The block SHALL have port oRAM_ERR  out  1  address out of range, qualified by oRAM_VALID.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP.
REQ-017 oRAM_READY SHALL be high in IDLE and RESP, and low in WAIT.
REQ-018 A request SHALL be accepted on a rising edge with iRAM_REQ & oRAM_READY; ADDR/WE/DATA/BE are latched at that edge.
REQ-019 On acceptance the FSM SHALL go to WAIT with counter = WAIT_STATES-1, or to RESP directly when WAIT_STATES = 0.
REQ-020 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-021 Array access (read sample or write commit) SHALL occur on the edge entering RESP; oRAM_VALID is high for exactly that RESP cycle.
REQ-022 Latency SHALL be WAIT_STATES+1 cycles from the accepting edge to oRAM_VALID high.
REQ-023 A request accepted in RESP SHALL be handled as one accepted in IDLE (back-to-back); with no request, RESP goes to IDLE.
REQ-024 For a read, oRAM_DATA SHALL equal mem[addr]; for a write, oRAM_DATA SHALL be 0.
REQ-025 oRAM_DATA SHALL hold its value until the next RESP.
REQ-026 Read-after-write to the same address SHALL return the written data, with no hazard.
REQ-027 Address >= DEPTH SHALL set oRAM_ERR=1 with oRAM_VALID, return read data 0, and leave memory untouched.
REQ-028 iRAM_REQ while oRAM_READY=0 SHALL be ignored (not queued); the requester holds the request.

Reset
REQ-029 On an edge with iRAM_RST=0, the block SHALL go to IDLE with counter=0, oRAM_VALID=0, oRAM_DATA=0, oRAM_ERR=0 and oRAM_READY=1 on the next cycle.
REQ-030 Reset mid-WAIT SHALL abort the transaction: a pending write is not committed and no response is issued.
REQ-031 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With MEMORY_RAM_BYTE_STROBE_EN defined, a write SHALL update only bytes whose iRAM_BE bit is 1; BE=0 completes normally with no change.
REQ-033 Without MEMORY_RAM_BYTE_STROBE_EN, iRAM_BE SHALL be ignored and every write updates the full word.

Structure
REQ-034 Package memory_ram_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), default parameter constants, and the WAIT_STATES maximum (15).
REQ-035 Sub-module memory_ram_array SHALL hold the storage (DEPTH x DATA_W, synchronous write with byte enables, synchronous read); the FSM and handshake stay in memory_ram_bus.

Verification
REQ-036 Reset, WAIT_STATES=1: write 0xDEADBEEF to addr 0x10 with BE=0xF, then read 0x10 -> read VALID 2 cycles after acceptance, DATA=0xDEADBEEF, ERR=0.
REQ-037 With MEMORY_RAM_BYTE_STROBE_EN: word 0x11223344, write 0xAABBCCDD with BE=0x5 -> readback 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-038 WAIT_STATES=0, REQ held high on alternating write/read of addr 3 -> VALID every cycle after the first, READY never low, read returns just-written value.
REQ-039 DEPTH=200: read addr 0xC8 -> VALID with ERR=1, DATA=0; write to 0xC8 then read 0x00 -> 0x00 unchanged.
REQ-040 WAIT_STATES=3: write accepted, iRAM_RST=0 on 2nd WAIT cycle -> no VALID, READY=1 next cycle, subsequent read of that addr returns the old value.
